// File: rtl/vga_scan_renderer_pkg.sv
// -----------------------------------------------------------------------------
// vga_scan_renderer_pkg
// Shared timing and colour constants for the VGA raster renderer and the game
// top level. The timing values describe standard 640x480@60 with a 25 MHz
// pixel clock. Colours are RGB332 (RRRGGGBB).
// -----------------------------------------------------------------------------
package vga_scan_renderer_pkg;

  // Counter width used for both h_cnt and v_cnt
  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // Default 640x480@60 timing, in pixels / lines
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  // RGB332 palette shared with the game logic
  localparam logic [7:0] RGB_BLACK = 8'h00;
  localparam logic [7:0] RGB_WHITE = 8'hFF;
  localparam logic [7:0] RGB_GREY  = 8'h92;
  localparam logic [7:0] RGB_RED   = 8'hE0;
  localparam logic [7:0] RGB_GREEN = 8'h1C;

endpackage

// File: rtl/vga_scan_renderer_timing_counter.sv
// -----------------------------------------------------------------------------
// vga_timing_counter
// Pixel-tick divider plus horizontal/vertical raster counters. Produces the
// undelayed sync, active and vblank levels and a one-clk frame_start pulse on
// the tick that moves v_cnt from the last active line into vertical blank.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   tick        high on the clk where the divider reaches CLK_DIV-1
//   h_cnt       horizontal pixel counter, 0..H_TOTAL-1
//   v_cnt       vertical line counter, 0..V_TOTAL-1
//   hs_raw      horizontal sync level for h_cnt (active-low)
//   vs_raw      vertical sync level for v_cnt (active-low)
//   active_raw  h_cnt/v_cnt inside the visible area
//   vblank      v_cnt >= V_ACTIVE
//   frame_start one-clk pulse at entry to vertical blank
// -----------------------------------------------------------------------------
module vga_timing_counter
  import vga_scan_renderer_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic hs_raw,
  output logic vs_raw,
  output logic active_raw,
  output logic vblank,
  output logic frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam cnt_t H_LAST     = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam cnt_t V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam cnt_t V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam cnt_t HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             line_end;
  logic             frame_end;

  assign tick      = (div == DIV_LAST);
  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + 1'b1;
      // Registered so the pulse lines up with vblank rising and lasts one clk
      frame_start <= tick && line_end && (v_cnt == V_ACT_LAST);
      if (tick) begin
        if (line_end) begin
          h_cnt <= '0;
          v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign hs_raw     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw     = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign active_raw = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign vblank     = (v_cnt >= V_ACT_C);

endmodule

// File: rtl/vga_scan_renderer.sv
// -----------------------------------------------------------------------------
// vga_scan_renderer
// Raster side of the object hit-test scheme. Presents the current pixel on
// poll_x/poll_y, waits HIT_LATENCY ticks for the hit-test blocks to answer,
// resolves the answer by layer priority (bit 0 wins) and drives RGB332 and the
// sync pins, with sync delayed by the same amount as colour.
//
// Ports:
//   clk         system clock (CLK_DIV clks per pixel)
//   reset       synchronous, active-low reset
//   hit_layers  registered hit flags from the hit-test blocks, bit 0 highest
//   poll_x      pixel X presented to hit-test blocks (0 outside active)
//   poll_y      pixel Y presented to hit-test blocks (0 outside active)
//   hsync       horizontal sync, active-low
//   vsync       vertical sync, active-low
//   rgb         pixel colour, RRRGGGBB
//   frame_start one-clk pulse at start of vertical blank
//   vblank      high while v_cnt >= V_ACTIVE
// -----------------------------------------------------------------------------
module vga_scan_renderer
  import vga_scan_renderer_pkg::*;
#(
  parameter int         CLK_DIV      = 2,
  parameter int         H_ACTIVE     = H_ACTIVE_DEF,
  parameter int         H_FP         = H_FP_DEF,
  parameter int         H_SYNC       = H_SYNC_DEF,
  parameter int         H_BP         = H_BP_DEF,
  parameter int         V_ACTIVE     = V_ACTIVE_DEF,
  parameter int         V_FP         = V_FP_DEF,
  parameter int         V_SYNC       = V_SYNC_DEF,
  parameter int         V_BP         = V_BP_DEF,
  parameter int         HIT_LATENCY  = 1,
  parameter logic [7:0] BG_COLOR     = RGB_BLACK,
  parameter logic [7:0] LAYER_COLOR0 = RGB_WHITE,
  parameter logic [7:0] LAYER_COLOR1 = RGB_GREY,
  parameter logic [7:0] LAYER_COLOR2 = RGB_RED,
  parameter logic [7:0] LAYER_COLOR3 = RGB_GREEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hit_layers,
  output logic [9:0] poll_x,
  output logic [8:0] poll_y,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_start,
  output logic       vblank
);

  localparam cnt_t H_ACT_C = CNT_W'(H_ACTIVE);
  localparam cnt_t V_ACT_C = CNT_W'(V_ACTIVE);

  function automatic logic [7:0] resolve_color(input logic [3:0] hits);
    logic [7:0] color;
    if (hits[0])      color = LAYER_COLOR0;
    else if (hits[1]) color = LAYER_COLOR1;
    else if (hits[2]) color = LAYER_COLOR2;
    else if (hits[3]) color = LAYER_COLOR3;
    else              color = BG_COLOR;
    return color;
  endfunction

  logic tick;
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic hs_raw;
  logic vs_raw;
  logic active_raw;

  vga_timing_counter #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .active_raw  (active_raw),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  // Stage p0: poll coordinates and the matching raw sync/active levels
  cnt_t       poll_x_p0;
  logic [8:0] poll_y_p0;
  logic       vld_p0;
  logic       hs_p0;
  logic       vs_p0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      poll_x_p0 <= '0;
      poll_y_p0 <= '0;
      vld_p0    <= 1'b0;
      hs_p0     <= 1'b1;
      vs_p0     <= 1'b1;
    end else if (tick) begin
      poll_x_p0 <= (h_cnt < H_ACT_C) ? h_cnt : '0;
      poll_y_p0 <= (v_cnt < V_ACT_C) ? 9'(v_cnt) : '0;
      vld_p0    <= active_raw;
      hs_p0     <= hs_raw;
      vs_p0     <= vs_raw;
    end
  end

  assign poll_x = poll_x_p0;
  assign poll_y = poll_y_p0;

  // Stage p1: HIT_LATENCY-deep delay matching the hit-test block response
  logic [HIT_LATENCY-1:0] vld_p1;
  logic [HIT_LATENCY-1:0] hs_p1;
  logic [HIT_LATENCY-1:0] vs_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1 <= '0;
      hs_p1  <= '1;
      vs_p1  <= '1;
    end else if (tick) begin
      vld_p1[0] <= vld_p0;
      hs_p1[0]  <= hs_p0;
      vs_p1[0]  <= vs_p0;
      for (int i = 1; i < HIT_LATENCY; i++) begin
        vld_p1[i] <= vld_p1[i-1];
        hs_p1[i]  <= hs_p1[i-1];
        vs_p1[i]  <= vs_p1[i-1];
      end
    end
  end

  // Stage p2: priority resolution and output registers
  logic [7:0] rgb_p2;
  logic       hsync_p2;
  logic       vsync_p2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_p2   <= '0;
      hsync_p2 <= 1'b1;
      vsync_p2 <= 1'b1;
    end else if (tick) begin
      rgb_p2   <= vld_p1[HIT_LATENCY-1] ? resolve_color(hit_layers) : 8'h00;
      hsync_p2 <= hs_p1[HIT_LATENCY-1];
      vsync_p2 <= vs_p1[HIT_LATENCY-1];
    end
  end

  assign rgb   = rgb_p2;
  assign hsync = hsync_p2;
  assign vsync = vsync_p2;

endmodule

// File: tb/tb_vga_scan_renderer.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_renderer
// Directed bench for vga_scan_renderer on a reduced raster (160x15 lines,
// 128x8 visible) so several whole frames fit in a short run. Expected values
// come from the timing formulas below: poll shows pixel k-1 after tick k,
// colour and sync show pixel k-3 (HIT_LATENCY+1 ticks behind poll).
// -----------------------------------------------------------------------------
module tb_vga_scan_renderer;

  localparam int HA = 128, HF = 8, HS = 16, HB = 8;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [7:0] C0 = 8'hFF, C1 = 8'h92, BG = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] hit_layers = 4'b0000;
  logic [9:0] poll_x;
  logic [8:0] poll_y;
  logic       hsync, vsync, frame_start, vblank;
  logic [7:0] rgb;

  vga_scan_renderer #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HIT_LATENCY(1),
    .BG_COLOR(BG), .LAYER_COLOR0(C0), .LAYER_COLOR1(C1),
    .LAYER_COLOR2(8'hE0), .LAYER_COLOR3(8'h1C)
  ) dut (
    .clk(clk), .reset(reset), .hit_layers(hit_layers),
    .poll_x(poll_x), .poll_y(poll_y), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .frame_start(frame_start), .vblank(vblank)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int k_tick = 0;
  int prev_poll = 0;
  int hs_low, vs_low, fs_cnt, c0_cnt, c1_cnt, first_p100_k, first_c0_k;

  task automatic do_tick(input int mode);
    int pp, hp, ln, pr, hp2, ln2, exp_px, exp_py;
    logic exp_hs, exp_vs, exp_vb, exp_fs, act;
    logic [7:0] exp_rgb;
    @(negedge clk);
    if (frame_start === 1'b1) fs_cnt++;
    @(negedge clk);
    k_tick++;
    if (frame_start === 1'b1) fs_cnt++;
    pp = k_tick - 1;
    hp = pp % HT;
    ln = (pp / HT) % VT;
    exp_px = (hp < HA) ? hp : 0;
    exp_py = (ln < VA) ? ln : 0;
    pr = k_tick - 3;
    if (pr < 0) begin
      exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 8'h00;
    end else begin
      hp2 = pr % HT;
      ln2 = (pr / HT) % VT;
      exp_hs = !((hp2 >= HA + HF) && (hp2 < HA + HF + HS));
      exp_vs = !((ln2 >= VA + VF) && (ln2 < VA + VF + VS));
      act = (hp2 < HA) && (ln2 < VA);
      if (!act) exp_rgb = 8'h00;
      else if (mode == 1) exp_rgb = (hp2 >= 100 && hp2 <= 103) ? C0 : BG;
      else if (mode == 2) exp_rgb = C1;
      else exp_rgb = BG;
    end
    exp_vb = ((k_tick / HT) % VT) >= VA;
    exp_fs = (k_tick % FRAME) == VA * HT;

    n_cmp++; if (poll_x !== 10'(exp_px)) begin n_bad++; $display("FAIL poll_x k=%0d got %0d want %0d", k_tick, poll_x, exp_px); end
    n_cmp++; if (poll_y !== 9'(exp_py)) begin n_bad++; $display("FAIL poll_y k=%0d got %0d want %0d", k_tick, poll_y, exp_py); end
    n_cmp++; if (hsync !== exp_hs) begin n_bad++; $display("FAIL hsync k=%0d got %b want %b", k_tick, hsync, exp_hs); end
    n_cmp++; if (vsync !== exp_vs) begin n_bad++; $display("FAIL vsync k=%0d got %b want %b", k_tick, vsync, exp_vs); end
    n_cmp++; if (rgb !== exp_rgb) begin n_bad++; $display("FAIL rgb k=%0d got %h want %h", k_tick, rgb, exp_rgb); end
    n_cmp++; if (vblank !== exp_vb) begin n_bad++; $display("FAIL vblank k=%0d got %b want %b", k_tick, vblank, exp_vb); end
    n_cmp++; if (frame_start !== exp_fs) begin n_bad++; $display("FAIL frame_start k=%0d got %b want %b", k_tick, frame_start, exp_fs); end

    if (hsync === 1'b0) hs_low++;
    if (vsync === 1'b0) vs_low++;
    if (rgb === C1) c1_cnt++;
    if (rgb === C0) begin
      c0_cnt++;
      if (first_c0_k < 0) first_c0_k = k_tick;
    end
    if (poll_x === 10'd100 && first_p100_k < 0) first_p100_k = k_tick;

    // Hit-test block model: registers its answer one tick after the poll
    case (mode)
      1: begin
        hit_layers = (prev_poll >= 100 && prev_poll <= 103) ? 4'b0001 : 4'b0000;
        prev_poll  = exp_px;
      end
      2:       hit_layers = 4'b0110;
      default: hit_layers = 4'b0000;
    endcase
  endtask

  task automatic run_ticks(input int n, input int mode);
    hs_low = 0; vs_low = 0; fs_cnt = 0; c0_cnt = 0; c1_cnt = 0;
    first_p100_k = -1; first_c0_k = -1;
    for (int i = 0; i < n; i++) do_tick(mode);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    k_tick = 0;
    prev_poll = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    hit_layers = 4'b0000;
    repeat (4) @(negedge clk);
    n_cmp++; if (poll_x !== 10'd0) begin n_bad++; $display("FAIL rst_poll_x got %0d want 0", poll_x); end
    n_cmp++; if (poll_y !== 9'd0) begin n_bad++; $display("FAIL rst_poll_y got %0d want 0", poll_y); end
    n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL rst_hsync got %b want 1", hsync); end
    n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL rst_vsync got %b want 1", vsync); end
    n_cmp++; if (rgb !== 8'h00) begin n_bad++; $display("FAIL rst_rgb got %h want 00", rgb); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_frame_start got %b want 0", frame_start); end
    n_cmp++; if (vblank !== 1'b0) begin n_bad++; $display("FAIL rst_vblank got %b want 0", vblank); end
    release_reset();
  endtask

  task automatic test_frame_timing();
    run_ticks(FRAME, 0);
    n_cmp++; if (hs_low != HS * VT) begin n_bad++; $display("FAIL hsync_low_ticks got %0d want %0d", hs_low, HS * VT); end
    n_cmp++; if (vs_low != VS * HT) begin n_bad++; $display("FAIL vsync_low_ticks got %0d want %0d", vs_low, VS * HT); end
    n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL frame_start_pulses got %0d want 1", fs_cnt); end
  endtask

  task automatic test_hit_alignment();
    run_ticks(FRAME, 1);
    n_cmp++; if (c0_cnt != 4 * VA) begin n_bad++; $display("FAIL hit_pixels got %0d want %0d", c0_cnt, 4 * VA); end
    n_cmp++; if (first_c0_k - first_p100_k != 2) begin n_bad++; $display("FAIL hit_latency got %0d want 2", first_c0_k - first_p100_k); end
    n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL hit_frame_start got %0d want 1", fs_cnt); end
  endtask

  task automatic test_priority();
    run_ticks(FRAME, 2);
    n_cmp++; if (c1_cnt != HA * VA) begin n_bad++; $display("FAIL priority_pixels got %0d want %0d", c1_cnt, HA * VA); end
  endtask

  task automatic test_frame_start_in_reset();
    int pulses;
    pulses = 0;
    reset = 1'b0;
    for (int i = 0; i < 3 * FRAME * 2; i++) begin
      @(negedge clk);
      if (frame_start !== 1'b0) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL fs_in_reset got %0d want 0", pulses); end
    n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL held_hsync got %b want 1", hsync); end
    n_cmp++; if (rgb !== 8'h00) begin n_bad++; $display("FAIL held_rgb got %h want 00", rgb); end
    release_reset();
  endtask

  task automatic test_back_to_back();
    run_ticks(FRAME, 0);
    n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL b2b_frame_start got %0d want 1", fs_cnt); end
    n_cmp++; if (hs_low != HS * VT) begin n_bad++; $display("FAIL b2b_hsync_low got %0d want %0d", hs_low, HS * VT); end
  endtask

  task automatic test_midframe_reset();
    // Run to poll (64,4) with layer 1 showing, then pull reset for 3 clk
    run_ticks(4 * HT + 64 + 1, 2);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL mid_hsync got %b want 1", hsync); end
    n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL mid_vsync got %b want 1", vsync); end
    n_cmp++; if (rgb !== 8'h00) begin n_bad++; $display("FAIL mid_rgb got %h want 00", rgb); end
    n_cmp++; if (poll_x !== 10'd0) begin n_bad++; $display("FAIL mid_poll_x got %0d want 0", poll_x); end
    n_cmp++; if (poll_y !== 9'd0) begin n_bad++; $display("FAIL mid_poll_y got %0d want 0", poll_y); end
    repeat (2) @(negedge clk);
    release_reset();
    run_ticks(FRAME, 0);
    n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL mid_frame_start got %0d want 1", fs_cnt); end
    n_cmp++; if (hs_low != HS * VT) begin n_bad++; $display("FAIL mid_hsync_low got %0d want %0d", hs_low, HS * VT); end
    n_cmp++; if (vs_low != VS * HT) begin n_bad++; $display("FAIL mid_vsync_low got %0d want %0d", vs_low, VS * HT); end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_hit_alignment();
    test_priority();
    test_frame_start_in_reset();
    test_back_to_back();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_renderer.md
Name: vga_scan_renderer

Overview:
- Raster-side counterpart to the game's object hit-test blocks.
- Generates 640x480@60 VGA timing and drives the poll coordinates (poll_x/poll_y) that every hit-test block samples.
- Collects their registered hit flags, resolves layer priority and drives the 8-bit RGB and sync pins.
- Emits a once-per-frame strobe so the game logic updates object positions during vertical blank.

Parameters:
- CLK_DIV, 2: clk cycles per pixel. The pixel tick is internal; the 50 MHz clk gives a 25 MHz pixel rate.
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing, in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing, in lines.
- HIT_LATENCY, 1: number of pixel ticks between a poll coordinate appearing and its hit flags being valid.
- BG_COLOR, 8'h00: background RGB332.
- LAYER_COLOR0..3, 8'hFF / 8'h92 / 8'hE0 / 8'h1C: colour per hit layer.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- hit_layers  input  4  hit flags from hit-test blocks; bit 0 has highest priority
- poll_x  output  10  current pixel X presented to hit-test blocks
- poll_y  output  9  current pixel Y presented to hit-test blocks
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- rgb  output  8  pixel colour, RRRGGGBB
- frame_start  output  1  one-clk pulse at start of vertical blank
- vblank  output  1  high while the (undelayed) v_cnt >= V_ACTIVE

Behaviour:
- Clock and reset:
  - One clock, clk. reset is synchronous and active-low; sampled only on the posedge of clk.
  - Reset values: tick divider 0, h_cnt 0, v_cnt 0, poll_x 0, poll_y 0, hsync 1, vsync 1, rgb 0, frame_start 0, vblank 0, delay pipeline cleared to inactive/sync-deasserted.
  - Reset asserted mid-frame: all of the above restored on the next edge. The first tick after release is pixel (0,0).
- Pixel tick:
  - Divider counts 0..CLK_DIV-1. tick is high when divider == CLK_DIV-1.
  - All counters and pipeline stages advance only on tick. Outputs hold between ticks.
- Counters:
  - H_TOTAL = 800, V_TOTAL = 525.
  - h_cnt wraps from H_TOTAL-1 to 0. v_cnt increments only when h_cnt wraps, and itself wraps from V_TOTAL-1 to 0.
  - Counter widths are 10 bits for both.
- Poll outputs (registered):
  - poll_x = h_cnt when h_cnt < H_ACTIVE, else 0.
  - poll_y = v_cnt when v_cnt < V_ACTIVE, else 0.
  - Values above 639 / 479 are never driven.
- Sync and active, undelayed:
  - hs_raw is low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw is low for v_cnt 490..491.
  - active_raw = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
- Alignment:
  - hs_raw, vs_raw and active_raw pass through a HIT_LATENCY-deep tick-enabled shift register before driving hsync, vsync and the active gate.
  - This keeps colour, sync and hit data pixel-aligned.
- Colour resolution (registered, on tick):
  - If delayed active is 0: rgb = 0.
  - Otherwise rgb = LAYER_COLORk for the lowest set bit k of hit_layers.
  - If no bit is set: rgb = BG_COLOR.
  - Multiple simultaneous hits: lowest index wins, with no blending.
- frame_start:
  - Pulses high for exactly one clk cycle, on the tick where v_cnt transitions 479 -> 480 (with h_cnt wrapping).
  - Never pulses during reset.
- Total latency from poll_x update to the matching rgb: HIT_LATENCY+1 ticks. hsync and vsync carry the same delay.

Decomposition:
- Shared package: timing localparams (H_TOTAL, V_TOTAL, sync start/end) and the RGB332 colour constants shared with the game top level.
- One natural sub-module, vga_timing_counter:
  - Contains the divider, h_cnt/v_cnt and the raw sync/active/vblank signals.
  - The renderer wraps it with the poll registers, delay line and priority mux.

Test Plan:
- Release reset, run one frame:
  - hsync low exactly 96 ticks per line, period 800 ticks.
  - vsync low for 2 lines, period 525 lines, i.e. 420000 ticks = 840000 clk.
- Poll sweep: capture poll_x/poll_y each tick.
  - Sequence is 0..639 then held at 0 for 160 ticks.
  - poll_y steps once per line, 0..479, with no value >479.
- Hit alignment: model one hit-test block registering hit for x in [100,103], any y.
  - rgb = LAYER_COLOR0 for exactly 4 ticks, corresponding to poll_x 100..103.
  - First coloured pixel appears HIT_LATENCY+1 ticks after poll_x=100.
- Priority: hit_layers = 4'b0110 -> rgb = LAYER_COLOR1. hit_layers = 4'b0000 -> rgb = BG_COLOR inside active, 0 during blanking.
- frame_start: exactly one pulse per frame, one clk wide, coincident with vblank rising; zero pulses across 3 frames while reset is held low.
- Mid-frame reset: assert reset at (320,200) for 3 clk.
  - Next clk shows hsync=vsync=1 and rgb=0.
  - After release, poll_x/poll_y restart at (0,0) and the frame completes with normal timing.
